// File: rtl/rotate_shift_pkg.sv
// -----------------------------------------------------------------------------
// rotate_shift_pkg
// Shared types and the single-stage move function for the pipelined
// rotate/shift unit.
//   rs_mode_e   : operation encoding (3'b101..3'b111 are reserved = pass-through)
//   rs_stage_f  : moves data by shift_amt positions within a width-bit word and
//                 returns {last bit moved out, result}; data is carried in a
//                 RS_MAX_W-bit container so one function serves every width.
// Optional feature macro used by the users of this package: ROTATE_SHIFT_CARRY_EN
// -----------------------------------------------------------------------------
package rotate_shift_pkg;

    localparam int RS_MODE_W = 3;
    localparam int RS_MAX_W  = 64;
    localparam int RS_IDX_W  = $clog2(RS_MAX_W);

    typedef logic [RS_IDX_W-1:0] rs_idx_t;

    typedef enum logic [RS_MODE_W-1:0] {
        RS_ROL = 3'd0,
        RS_ROR = 3'd1,
        RS_SHL = 3'd2,
        RS_SHR = 3'd3,
        RS_SAR = 3'd4
    } rs_mode_e;

    // Result bit i is picked from a source bit (or fill value) according to
    // mode. Bits at and above width stay zero. The returned MSB is the last
    // bit that left the word when shifting one position at a time.
    function automatic logic [RS_MAX_W:0] rs_stage_f(
        input logic [RS_MAX_W-1:0]  data,
        input logic [RS_MODE_W-1:0] mode,
        input int                   shift_amt,
        input int                   width
    );
        logic [RS_MAX_W-1:0] res;
        logic                cout;
        res  = '0;
        cout = 1'b0;
        for (int i = 0; i < RS_MAX_W; i++) begin
            if (i < width) begin
                res[i] = data[rs_idx_t'(i)];
                case (mode)
                    RS_ROL: res[i] = data[rs_idx_t'((i - shift_amt + width) % width)];
                    RS_ROR: res[i] = data[rs_idx_t'((i + shift_amt) % width)];
                    RS_SHL: res[i] = (i >= shift_amt) ? data[rs_idx_t'(i - shift_amt)] : 1'b0;
                    RS_SHR: res[i] = (i + shift_amt < width) ? data[rs_idx_t'(i + shift_amt)] : 1'b0;
                    RS_SAR: res[i] = (i + shift_amt < width) ? data[rs_idx_t'(i + shift_amt)]
                                                             : data[rs_idx_t'(width - 1)];
                    default: ;
                endcase
            end
        end
        case (mode)
            RS_ROL, RS_SHL:         cout = data[rs_idx_t'(width - shift_amt)];
            RS_ROR, RS_SHR, RS_SAR: cout = data[rs_idx_t'(shift_amt - 1)];
            default:                cout = 1'b0;
        endcase
        return {cout, res};
    endfunction

endpackage

// File: rtl/rotate_shift_stage.sv
// -----------------------------------------------------------------------------
// rotate_shift_stage
// One registered barrel stage: moves the operand by SHIFT positions when the
// matching amount bit is set, then registers data, amount, mode and valid
// behind a valid/ready skid-less handshake (loads when empty or draining).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake (in_ready is combinational)
//   data_i, amt_i, mode_i operand, full amount, operation select
//   out_valid / out_ready downstream handshake
//   data_o, amt_o, mode_o registered stage outputs
//   carry_i / carry_o     last bit moved out (only with ROTATE_SHIFT_CARRY_EN)
// -----------------------------------------------------------------------------
module rotate_shift_stage
    import rotate_shift_pkg::*;
#(
    parameter int N     = 8,
    parameter int SHIFT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          data_i,
    input  logic [$clog2(N)-1:0]  amt_i,
    input  logic [RS_MODE_W-1:0]  mode_i,
`ifdef ROTATE_SHIFT_CARRY_EN
    input  logic                  carry_i,
    output logic                  carry_o,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          data_o,
    output logic [$clog2(N)-1:0]  amt_o,
    output logic [RS_MODE_W-1:0]  mode_o
);

    localparam int AW  = $clog2(N);
    localparam int BIT = $clog2(SHIFT);

    logic                 vld_q, vld_d;
    logic [N-1:0]         data_q, data_d;
    logic [AW-1:0]        amt_q, amt_d;
    logic [RS_MODE_W-1:0] mode_q, mode_d;
`ifdef ROTATE_SHIFT_CARRY_EN
    logic                 carry_q, carry_d;
`endif
    logic [RS_MAX_W:0]    stage_res;
    logic                 move;
    logic                 load;
    logic                 unused_res;

    always_comb begin
        load      = ~vld_q | out_ready;
        in_ready  = load;
        stage_res = rs_stage_f(RS_MAX_W'(data_i), mode_i, SHIFT, N);
        // Reserved modes behave as amount 0: no move, carry untouched.
        move      = amt_i[BIT] & (mode_i <= RS_SAR);
        vld_d     = load ? in_valid : vld_q;
        data_d    = data_q;
        amt_d     = amt_q;
        mode_d    = mode_q;
`ifdef ROTATE_SHIFT_CARRY_EN
        carry_d   = carry_q;
`endif
        if (load && in_valid) begin
            data_d  = move ? stage_res[N-1:0] : data_i;
            amt_d   = amt_i;
            mode_d  = mode_i;
`ifdef ROTATE_SHIFT_CARRY_EN
            carry_d = move ? stage_res[RS_MAX_W] : carry_i;
`endif
        end
    end

    // Container bits above N (and carry when the feature is off) are not used.
    assign unused_res = ^stage_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            mode_q  <= '0;
`ifdef ROTATE_SHIFT_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            vld_q   <= vld_d;
            data_q  <= data_d;
            amt_q   <= amt_d;
            mode_q  <= mode_d;
`ifdef ROTATE_SHIFT_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign out_valid = vld_q;
    assign data_o    = data_q;
    assign amt_o     = amt_q;
    assign mode_o    = mode_q;
`ifdef ROTATE_SHIFT_CARRY_EN
    assign carry_o   = carry_q;
`endif

endmodule

// File: rtl/rotate_shift_pipe_op.sv
// -----------------------------------------------------------------------------
// rotate_shift_pipe_op
// Pipelined rotate / shift unit (ROL, ROR, SHL, SHR, SAR) built from LOG2N
// registered barrel stages; stage s moves by 2^s. Full valid/ready
// backpressure, latency LOG2N, throughput one result per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake
//   a, b, mode            operand, amount (only b[LOG2N-1:0] used), operation
//   out_valid / out_ready result handshake
//   out                   result, driven straight from the last stage register
//   carry                 last bit moved out (only with ROTATE_SHIFT_CARRY_EN)
// -----------------------------------------------------------------------------
module rotate_shift_pipe_op
    import rotate_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         a,
    input  logic [N-1:0]         b,
    input  logic [RS_MODE_W-1:0] mode,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef ROTATE_SHIFT_CARRY_EN
    output logic                 carry,
`endif
    output logic [N-1:0]         out
);

    localparam int LOG2N = $clog2(N);

    if (N < 2 || (N & (N - 1)) != 0 || N > RS_MAX_W) begin : g_bad_n
        $error("rotate_shift_pipe_op: N must be a power of 2 in 2..64");
    end

    // Index s is the input of stage s; index LOG2N is the pipe output.
    logic [LOG2N:0][N-1:0]         data_s;
    logic [LOG2N:0][LOG2N-1:0]     amt_s;
    logic [LOG2N:0][RS_MODE_W-1:0] mode_s;
    logic [LOG2N:0]                vld_s;
    logic [LOG2N:0]                rdy_s;
`ifdef ROTATE_SHIFT_CARRY_EN
    logic [LOG2N:0]                carry_s;
`endif
    logic                          unused_tail;

    assign data_s[0]    = a;
    assign amt_s[0]     = b[LOG2N-1:0];
    assign mode_s[0]    = mode;
    assign vld_s[0]     = in_valid;
    assign in_ready     = rdy_s[0];
    assign rdy_s[LOG2N] = out_ready;
    assign out          = data_s[LOG2N];
    assign out_valid    = vld_s[LOG2N];
`ifdef ROTATE_SHIFT_CARRY_EN
    assign carry_s[0]   = 1'b0;
    assign carry        = carry_s[LOG2N];
`endif

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        rotate_shift_stage #(
            .N     (N),
            .SHIFT (1 << s)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vld_s[s]),
            .in_ready  (rdy_s[s]),
            .data_i    (data_s[s]),
            .amt_i     (amt_s[s]),
            .mode_i    (mode_s[s]),
`ifdef ROTATE_SHIFT_CARRY_EN
            .carry_i   (carry_s[s]),
            .carry_o   (carry_s[s+1]),
`endif
            .out_valid (vld_s[s+1]),
            .out_ready (rdy_s[s+1]),
            .data_o    (data_s[s+1]),
            .amt_o     (amt_s[s+1]),
            .mode_o    (mode_s[s+1])
        );
    end

    // Upper amount bits are ignored; amount/mode leaving the last stage are spent.
    assign unused_tail = ^{b[N-1:LOG2N], amt_s[LOG2N], mode_s[LOG2N]};

endmodule
